// File: rtl/multi_hazard_ctrl.sv
// multi_hazard_ctrl: pipeline hazard controller.
// Arbitrates dmem stalls, multi-cycle EX ops, EX-stage redirects, load-use
// hazards and imem stalls, and drives the pipeline stall/flush controls.
// Optional feature macro: HAZARD_NO_FORWARD_EN (no forwarding paths, so any
// in-flight register write that matches an ID source stalls ID).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | normal flow; events are arbitrated by priority
// MULTI      | multi-cycle op resident in EX, counting down its latency
// REDIR_PEND | redirect taken while imem busy; saved target awaits imem
module multi_hazard_ctrl #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic            ex_multi,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            stall_idex,
  output logic            stall_exmem,
  output logic            stall_memwb,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  output logic            multi_busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MULTI      = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  // The IDLE cycle that accepts the op is the first EX-resident cycle and
  // the MULTI exit cycle is the last, so MULTI counts MUL_LAT-2 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

`ifdef HAZARD_NO_FORWARD_EN
  localparam logic NO_FWD = 1'b1;
`else
  localparam logic NO_FWD = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              done_q, done_d;

  logic rs_hit_ex, rs_hit_mem, load_use, alu_dep, data_hazard;

  // Source/destination match terms; x0 never produces a hazard
  always_comb begin
    rs_hit_ex   = (ex_rd != 5'd0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));
    rs_hit_mem  = (mem_rd != 5'd0) &&
                  ((id_rs1_used && (id_rs1 == mem_rd)) ||
                   (id_rs2_used && (id_rs2 == mem_rd)));
    load_use    = ex_mem_read && ex_reg_write && rs_hit_ex;
    alu_dep     = (ex_reg_write && rs_hit_ex) || (mem_reg_write && rs_hit_mem);
    data_hazard = load_use || (NO_FWD && alu_dep);
  end

  // Next-state and output decode, in priority order
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tgt_d           = tgt_q;
    done_d          = done_q;
    stall_pc        = 1'b0;
    stall_ifid      = 1'b0;
    stall_idex      = 1'b0;
    stall_exmem     = 1'b0;
    stall_memwb     = 1'b0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;
    flush_exmem     = 1'b0;
    redirect_valid  = 1'b0;
    multi_busy      = (state_q == MULTI);
    redirect_target = (state_q == REDIR_PEND) ? tgt_q : ex_target;

    if (!dmem_ready) begin
      // Whole pipeline freezes; controller state holds
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          // done_q masks the op that just finished and is now leaving EX
          if (ex_multi && !done_q) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            flush_exmem = 1'b1;
            cnt_d       = CNT_INIT;
            state_d     = MULTI;
          end else if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (imem_ready) begin
              redirect_valid = 1'b1;
            end else begin
              stall_pc = 1'b1;
              tgt_d    = ex_target;
              state_d  = REDIR_PEND;
            end
          end else if (data_hazard || !imem_ready) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
        MULTI: begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          flush_exmem = 1'b1;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        REDIR_PEND: begin
          flush_ifid = 1'b1;
          if (imem_ready) begin
            redirect_valid = 1'b1;
            state_d        = IDLE;
          end else begin
            stall_pc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Reset quiets every output regardless of state
    if (reset) begin
      stall_pc        = 1'b0;
      stall_ifid      = 1'b0;
      stall_idex      = 1'b0;
      stall_exmem     = 1'b0;
      stall_memwb     = 1'b0;
      flush_ifid      = 1'b0;
      flush_idex      = 1'b0;
      flush_exmem     = 1'b0;
      redirect_valid  = 1'b0;
      multi_busy      = 1'b0;
      redirect_target = '0;
    end
  end

  // State, counter, saved target and done flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_multi_hazard_ctrl.sv
// Scoreboard bench for multi_hazard_ctrl (MUL_LAT=4, XLEN=32).
module tb_multi_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write;
  logic        ex_multi, ex_redirect, imem_ready, dmem_ready;
  logic [31:0] ex_target;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, redirect_valid, multi_busy;
  logic [31:0] redirect_target;

  multi_hazard_ctrl #(.XLEN(32), .MUL_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_multi(ex_multi), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .multi_busy(multi_busy)
  );

  always #5 clk = ~clk;

  // Output bundle bit positions
  localparam logic [9:0] SPC = 10'h200, SIF = 10'h100, SID = 10'h080,
                         SEX = 10'h040, SMW = 10'h020, FIF = 10'h010,
                         FID = 10'h008, FEX = 10'h004, RV  = 10'h002,
                         BSY = 10'h001;
  localparam logic [9:0] MUL  = SPC | SIF | SID | FEX;
  localparam logic [9:0] ALLS = SPC | SIF | SID | SEX | SMW;
  localparam logic [9:0] LU   = SPC | SIF | FID;
`ifdef HAZARD_NO_FORWARD_EN
  localparam logic [9:0] NF_EXP = LU;
`else
  localparam logic [9:0] NF_EXP = 10'h000;
`endif

  typedef struct {
    logic [9:0]  ctl;
    logic [31:0] tgt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  logic [9:0] mon_got;
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: pops one expectation per cycle, away from the active edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x   = sb_q.pop_front();
      mon_got = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                 flush_ifid, flush_idex, flush_exmem, redirect_valid, multi_busy};
      n_checks++;
      if (mon_got !== mon_x.ctl || redirect_target !== mon_x.tgt) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b tgt=%h, required ctl=%b tgt=%h",
                 mon_x.name, mon_got, redirect_target, mon_x.ctl, mon_x.tgt);
      end
    end
  end

  task automatic vec(input string nm, input logic [9:0] e, input logic [31:0] t);
    exp_t x;
    x.ctl  = e;
    x.tgt  = t;
    x.name = nm;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0;
    ex_multi = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;

    // Reset: outputs quiet even with active inputs
    vec("reset_idle", 10'h000, 32'h0);
    ex_multi = 1'b1; ex_redirect = 1'b1; ex_target = 32'h44;
    vec("reset_inputs", 10'h000, 32'h0);
    reset = 1'b0; clr();
    ex_target = 32'h40;
    vec("idle_quiet", 10'h000, 32'h40);
    clr();

    // Multi-cycle op held, with a simultaneous redirect on the first cycle
    ex_multi = 1'b1; ex_redirect = 1'b1;
    vec("multi_c1", MUL, 32'h0);
    ex_redirect = 1'b0;
    vec("multi_c2", MUL | BSY, 32'h0);
    vec("multi_c3", MUL | BSY, 32'h0);
    vec("multi_c4", MUL | BSY, 32'h0);
    vec("multi_done", 10'h000, 32'h0);
    clr();
    vec("multi_after", 10'h000, 32'h0);

    // Immediate redirect
    ex_redirect = 1'b1; ex_target = 32'h100;
    vec("redir_now", RV | FIF | FID, 32'h100);
    clr();
    vec("redir_now_after", 10'h000, 32'h0);

    // Redirect pending on imem for 3 cycles
    ex_redirect = 1'b1; ex_target = 32'h80; imem_ready = 1'b0;
    vec("redir_pend_c1", SPC | FIF | FID, 32'h80);
    ex_redirect = 1'b0; ex_target = 32'h0;
    vec("redir_pend_c2", SPC | FIF, 32'h80);
    vec("redir_pend_c3", SPC | FIF, 32'h80);
    imem_ready = 1'b1;
    vec("redir_pend_fire", RV | FIF, 32'h80);
    vec("redir_pend_after", 10'h000, 32'h0);

    // Load-use on rs2, then bubble, then x0 and unused-source cases
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_rs2_used = 1'b1;
    vec("lu_rs2", LU, 32'h0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    vec("lu_bubble", 10'h000, 32'h0);
    clr();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
    id_rs2 = 5'd0; id_rs2_used = 1'b1;
    vec("lu_x0", 10'h000, 32'h0);
    clr();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
    id_rs1 = 5'd9; id_rs1_used = 1'b1;
    vec("lu_rs1", LU, 32'h0);
    id_rs1_used = 1'b0;
    vec("lu_rs1_unused", 10'h000, 32'h0);
    clr();

    // ALU dependencies: stall only without forwarding
    mem_reg_write = 1'b1; mem_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    vec("nf_mem_rd", NF_EXP, 32'h0);
    clr();
    ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1;
    vec("nf_ex_rd", NF_EXP, 32'h0);
    clr();

    // imem stall alone
    imem_ready = 1'b0;
    vec("imem_stall", LU, 32'h0);
    clr();

    // dmem stall overrides a redirect and leaves no trace
    dmem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h20;
    vec("dmem_over_redir", ALLS, 32'h20);
    dmem_ready = 1'b1;
    vec("redir_after_dmem", RV | FIF | FID, 32'h20);
    clr();

    // dmem stall in the middle of a multi-cycle op stretches it by 2
    ex_multi = 1'b1;
    vec("md_c1", MUL, 32'h0);
    vec("md_c2", MUL | BSY, 32'h0);
    dmem_ready = 1'b0;
    vec("md_dmem1", ALLS | BSY, 32'h0);
    vec("md_dmem2", ALLS | BSY, 32'h0);
    dmem_ready = 1'b1;
    vec("md_c3", MUL | BSY, 32'h0);
    vec("md_c4", MUL | BSY, 32'h0);
    vec("md_done", 10'h000, 32'h0);
    clr();

    // Reset while a redirect is pending
    ex_redirect = 1'b1; ex_target = 32'h200; imem_ready = 1'b0;
    vec("rp_enter", SPC | FIF | FID, 32'h200);
    ex_redirect = 1'b0; ex_target = 32'h0; reset = 1'b1;
    vec("rp_reset", 10'h000, 32'h0);
    reset = 1'b0; imem_ready = 1'b1;
    vec("rp_no_redirect", 10'h000, 32'h0);
    clr();

    // Reset in the middle of a multi-cycle op
    ex_multi = 1'b1;
    vec("mr_c1", MUL, 32'h0);
    vec("mr_c2", MUL | BSY, 32'h0);
    reset = 1'b1; ex_multi = 1'b0;
    vec("mr_reset", 10'h000, 32'h0);
    reset = 1'b0;
    vec("mr_after", 10'h000, 32'h0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
